// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  // IDLE: no read in flight. WAIT: a read is outstanding.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  // Which requester the outstanding read belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_lat_tracker.sv
// Tracks the single outstanding read: latency down-counter plus owner tag.
// Produces per-owner rvalid strobes and the arbitration-eligible flag.
//
// state | meaning
// IDLE  | no read in flight, a grant may issue
// WAIT  | read in flight; final cycle is cnt==1, which also allows a grant
module arb_lat_tracker
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   issue,
  input  owner_t issue_owner,
  output logic   rvalid_if,
  output logic   rvalid_dm,
  output logic   eligible,
  output logic   ready
);

  localparam int CW = $clog2(RD_LAT + 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  owner_t        owner;
  logic          ready_q;
  logic          last;

  // The read returns in the WAIT cycle where the counter has reached one.
  assign last      = (state == WAIT) && (cnt == CW'(1));
  // ready_q holds everything quiet for the first cycle after reset release.
  assign ready     = ready_q;
  assign eligible  = ready_q && ((state == IDLE) || last);
  assign rvalid_if = last && (owner == OWN_IF);
  assign rvalid_dm = last && (owner == OWN_DM);

  // Latency counter, owner tag and state; a new read may chain on the return cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= OWN_NONE;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (issue && eligible) begin
        state <= WAIT;
        cnt   <= CW'(RD_LAT);
        owner <= issue_owner;
      end else if (last) begin
        state <= IDLE;
        cnt   <= '0;
        owner <= OWN_NONE;
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and the
// data side (DM). Data side has strict priority; with ARB_STARVE_GUARD_EN
// defined, a starvation counter lets a long-waiting fetch win once.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          pipe_stall
);

  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("RD_LAT must be at least 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  logic   eligible;
  logic   ready;
  logic   rvalid_if_w;
  logic   rvalid_dm_w;
  logic   if_prio;
  logic   dm_win;
  logic   if_win;
  logic   issue;
  owner_t issue_owner;

  arb_lat_tracker #(
    .RD_LAT(RD_LAT)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_owner(issue_owner),
    .rvalid_if  (rvalid_if_w),
    .rvalid_dm  (rvalid_dm_w),
    .eligible   (eligible),
    .ready      (ready)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign if_prio = if_req && (starve_cnt == SW'(STARVE_MAX));

  // Count eligible cycles in which fetch asked and lost; saturate, clear on a fetch grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_win) begin
      starve_cnt <= '0;
    end else if (eligible && if_req && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign if_prio = 1'b0;
`endif

  assign dm_win      = eligible && dm_req && !if_prio;
  assign if_win      = eligible && if_req && !dm_win;
  assign issue       = if_win || (dm_win && !dm_we);
  assign issue_owner = if_win ? OWN_IF : OWN_DM;

  assign if_gnt     = if_win;
  assign dm_gnt     = dm_win;
  assign if_rvalid  = rvalid_if_w;
  assign dm_rvalid  = rvalid_dm_w;
  assign if_rdata   = rvalid_if_w ? mem_rdata : '0;
  assign dm_rdata   = rvalid_dm_w ? mem_rdata : '0;
  assign pipe_stall = ready && if_req && !if_win;

  // Memory strobe and operands come straight from the winner, zero otherwise.
  always_comb begin
    mem_en    = if_win || dm_win;
    mem_we    = dm_win && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_win) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_win) begin
      mem_addr = if_addr;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Instance a uses RD_LAT=1,
// instance b uses RD_LAT=3. Honours ARB_STARVE_GUARD_EN when defined.
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int SMAX  = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef logic [107:0] obus_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, mem_init;

  logic        a_if_req, a_if_gnt, a_if_rvalid, a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid;
  logic        a_mem_en, a_mem_we, a_pipe_stall;
  logic [4:0]  a_if_addr, a_dm_addr, a_mem_addr;
  logic [31:0] a_if_rdata, a_dm_wdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;

  logic        b_if_req, b_if_gnt, b_if_rvalid, b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
  logic        b_mem_en, b_mem_we, b_pipe_stall;
  logic [4:0]  b_if_addr, b_dm_addr, b_mem_addr;
  logic [31:0] b_if_rdata, b_dm_wdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.AW(5), .DW(32), .RD_LAT(LAT_A), .STARVE_MAX(SMAX)) dut_a (
    .clk(clk), .rst_n(rst_a),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .pipe_stall(a_pipe_stall)
  );

  mem_port_arbiter #(.AW(5), .DW(32), .RD_LAT(LAT_B), .STARVE_MAX(SMAX)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .pipe_stall(b_pipe_stall)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    if (i == 7) w = 32'hFFFF_FFFF;
    else        w = {i[15:0], 16'(i - 1)};
    return w;
  endfunction

  // Memory behind instance a: one-cycle read pipeline, garbage when not reading.
  logic [31:0] mem_a [32];
  logic [31:0] pipe_a;
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 32; i++) mem_a[i] <= init_word(i);
    else if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    pipe_a <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : 32'hDEAD_BEEF;
  end
  assign a_mem_rdata = pipe_a;

  // Memory behind instance b: three-cycle read pipeline.
  logic [31:0] mem_b [32];
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 32; i++) mem_b[i] <= init_word(i);
    else if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 32'hDEAD_BEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obus_t mk(input logic ig, input logic dg, input logic irv,
                               input logic [31:0] ird, input logic drv, input logic [31:0] drd,
                               input logic men, input logic mwe, input logic [4:0] madr,
                               input logic [31:0] mwd, input logic stall);
    return {ig, dg, irv, ird, drv, drd, men, mwe, madr, mwd, stall};
  endfunction

  function automatic obus_t bus_a();
    return {a_if_gnt, a_dm_gnt, a_if_rvalid, a_if_rdata, a_dm_rvalid, a_dm_rdata,
            a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_pipe_stall};
  endfunction

  function automatic obus_t bus_b();
    return {b_if_gnt, b_dm_gnt, b_if_rvalid, b_if_rdata, b_dm_rvalid, b_dm_rdata,
            b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_pipe_stall};
  endfunction

  typedef struct {
    logic        ifr;
    logic [4:0]  ifa;
    logic        dmr;
    logic        dmwe;
    logic [4:0]  dma;
    logic [31:0] dmwd;
    obus_t       exp;
  } vec_t;

  vec_t tbl [16];

  // Reference model state for the randomized phase.
  int          now;
  logic        pv;
  int          pdue;
  logic        pown_dm;
  logic [31:0] pdata;
  logic [31:0] rmem [32];
  int          starve;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        elig, ret, irv, drv, if_w, dm_w, if_done, dm_done, exp_ig;
    obus_t       e;

    rst_a = 1'b0; rst_b = 1'b0; mem_init = 1'b1;
    a_if_req = 1'b1; a_if_addr = 5'd3; a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_addr = '0; a_dm_wdata = '0;
    b_if_req = 1'b1; b_if_addr = 5'd3; b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;

    // Table of single-cycle vectors for instance a (RD_LAT=1), first row is the
    // first cycle after reset release.
    tbl[0]  = '{1, 3, 0, 0, 0, 0,       mk(1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0)};
    tbl[1]  = '{0, 0, 0, 0, 0, 0,       mk(0, 0, 1, 32'h0003_0002, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1, 5, 1, 0, 7, 0,       mk(0, 1, 0, 0, 0, 0, 1, 0, 7, 0, 1)};
    tbl[3]  = '{1, 5, 0, 0, 0, 0,       mk(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 5, 0, 0)};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,       mk(0, 0, 1, 32'h0005_0004, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{0, 0, 1, 1, 2, 5,       mk(0, 1, 0, 0, 0, 0, 1, 1, 2, 5, 0)};
    tbl[6]  = '{0, 0, 1, 0, 2, 0,       mk(0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0)};
    tbl[7]  = '{0, 0, 0, 0, 0, 0,       mk(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0)};
    tbl[8]  = '{0, 0, 1, 0, 4, 0,       mk(0, 1, 0, 0, 0, 0, 1, 0, 4, 0, 0)};
    tbl[9]  = '{0, 0, 1, 0, 6, 0,       mk(0, 1, 0, 0, 1, 32'h0004_0003, 1, 0, 6, 0, 0)};
    tbl[10] = '{0, 0, 0, 0, 0, 0,       mk(0, 0, 0, 0, 1, 32'h0006_0005, 0, 0, 0, 0, 0)};
    tbl[11] = '{1, 9, 1, 1, 10, 32'hAB, mk(0, 1, 0, 0, 0, 0, 1, 1, 10, 32'hAB, 1)};
    tbl[12] = '{1, 9, 0, 0, 0, 0,       mk(1, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0)};
    tbl[13] = '{0, 0, 0, 0, 0, 0,       mk(0, 0, 1, 32'h0009_0008, 0, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{0, 0, 1, 0, 10, 0,      mk(0, 1, 0, 0, 0, 0, 1, 0, 10, 0, 0)};
    tbl[15] = '{0, 0, 0, 0, 0, 0,       mk(0, 0, 0, 0, 1, 32'hAB, 0, 0, 0, 0, 0)};

    repeat (3) tick();
    mem_init = 1'b0;
    @(negedge clk);
    check("reset_a", 128'(bus_a()), 128'(obus_t'(0)));
    check("reset_b", 128'(bus_b()), 128'(obus_t'(0)));
    rst_a = 1'b1; rst_b = 1'b1;
    b_if_req = 1'b0;
    #1;
    check("release_a", 128'(bus_a()), 128'(obus_t'(0)));
    tick();

    for (int i = 0; i < 16; i++) begin
      a_if_req = tbl[i].ifr; a_if_addr = tbl[i].ifa;
      a_dm_req = tbl[i].dmr; a_dm_we = tbl[i].dmwe; a_dm_addr = tbl[i].dma; a_dm_wdata = tbl[i].dmwd;
      @(negedge clk);
      check($sformatf("table_row%0d", i), 128'(bus_a()), 128'(tbl[i].exp));
      tick();
    end

    // Data side requests every cycle while fetch waits.
    a_if_req = 1'b1; a_if_addr = 5'd1; a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 5'd4; a_dm_wdata = '0;
    for (int k = 1; k <= 6; k++) begin
      exp_ig = GUARD && (k == 5);
      @(negedge clk);
      check($sformatf("starve_cycle%0d", k), 128'({a_if_gnt, a_dm_gnt, a_pipe_stall}),
            128'({exp_ig, !exp_ig, a_if_req && !exp_ig}));
      tick();
      if (exp_ig) a_if_req = 1'b0;
    end
    a_if_req = 1'b0; a_dm_req = 1'b0;
    tick();
    tick();

    // Instance b: RD_LAT=3 read with a fetch waiting behind it.
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 5'd7;
    @(negedge clk);
    check("lat3_grant", 128'(bus_b()), 128'(mk(0, 1, 0, 0, 0, 0, 1, 0, 7, 0, 0)));
    tick();
    b_dm_req = 1'b0; b_if_req = 1'b1; b_if_addr = 5'd3;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check($sformatf("lat3_wait%0d", k), 128'(bus_b()), 128'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      tick();
    end
    @(negedge clk);
    check("lat3_return", 128'(bus_b()), 128'(mk(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 3, 0, 0)));
    tick();
    b_if_req = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) check("lat3_if_return", 128'(bus_b()), 128'(mk(0, 0, 1, 32'h0003_0002, 0, 0, 0, 0, 0, 0, 0)));
      else        check($sformatf("lat3_quiet%0d", k), 128'(bus_b()), 128'(obus_t'(0)));
      tick();
    end

    // Instance b: reset one cycle into an RD_LAT=3 read.
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 5'd7;
    @(negedge clk);
    check("midrst_grant", 128'(bus_b()), 128'(mk(0, 1, 0, 0, 0, 0, 1, 0, 7, 0, 0)));
    tick();
    b_dm_req = 1'b0;
    rst_b = 1'b0;
    #1;
    check("midrst_in_reset", 128'(bus_b()), 128'(obus_t'(0)));
    @(negedge clk);
    rst_b = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("midrst_no_rvalid_t%0d", k), 128'({b_if_rvalid, b_dm_rvalid, b_dm_rdata}), 128'(0));
    end
    tick();
    b_if_req = 1'b1; b_if_addr = 5'd3;
    @(negedge clk);
    check("postrst_grant", 128'(bus_b()), 128'(mk(1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0)));
    tick();
    b_if_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) check("postrst_return", 128'(bus_b()), 128'(mk(0, 0, 1, 32'h0003_0002, 0, 0, 0, 0, 0, 0, 0)));
      else        check($sformatf("postrst_quiet%0d", k), 128'(bus_b()), 128'(obus_t'(0)));
      tick();
    end

    // Randomized phase on instance a against a cycle-counting reference model.
    a_if_req = 1'b0; a_dm_req = 1'b0;
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    for (int i = 0; i < 32; i++) rmem[i] = init_word(i);
    tick();
    now = 0; pv = 1'b0; pdue = 0; pown_dm = 1'b0; pdata = '0; starve = 0;
    if_done = 1'b1; dm_done = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (if_done || !a_if_req) begin
        a_if_req  = ($urandom_range(0, 3) != 0);
        a_if_addr = 5'($urandom);
      end
      if (dm_done || !a_dm_req) begin
        a_dm_req   = ($urandom_range(0, 2) != 0);
        a_dm_we    = ($urandom_range(0, 2) == 0);
        a_dm_addr  = 5'($urandom);
        a_dm_wdata = a_dm_we ? $urandom : 32'h0;
      end
      @(negedge clk);
      elig = !pv || (pdue == now);
      ret  = pv && (pdue == now);
      irv  = ret && !pown_dm;
      drv  = ret && pown_dm;
      if_w = 1'b0;
      dm_w = 1'b0;
      if (elig) begin
        if (GUARD && a_if_req && (starve >= SMAX)) if_w = 1'b1;
        else if (a_dm_req)                           dm_w = 1'b1;
        else if (a_if_req)                           if_w = 1'b1;
      end
      e = mk(if_w, dm_w, irv, irv ? pdata : 32'h0, drv, drv ? pdata : 32'h0,
             if_w || dm_w, dm_w && a_dm_we,
             dm_w ? a_dm_addr : (if_w ? a_if_addr : 5'h0),
             dm_w ? a_dm_wdata : 32'h0, a_if_req && !if_w);
      check($sformatf("random_cycle%0d", c), 128'(bus_a()), 128'(e));
      if (ret) pv = 1'b0;
      if (dm_w && a_dm_we) begin
        rmem[a_dm_addr] = a_dm_wdata;
      end else if (dm_w || if_w) begin
        pv      = 1'b1;
        pdue    = now + LAT_A;
        pown_dm = dm_w;
        pdata   = rmem[dm_w ? a_dm_addr : a_if_addr];
      end
      if (if_w)                                       starve = 0;
      else if (elig && a_if_req && (starve < SMAX))   starve++;
      if_done = if_w;
      dm_done = dm_w;
      now++;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 32-bit memory between the instruction-fetch side (IF) and the data-memory side (MEM stage), giving the pipeline a unified memory.
- Arbitrates one access per grant, tracks the outstanding read and routes the returned data to its owner.
- Drives pipe_stall so the pipeline controller can freeze the PC and the IF/ID register while fetch is blocked.

Parameters:
- AW, 5, word-address width (32-entry memory).
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles; must be ≥1.
- STARVE_MAX, 4, starvation threshold for IF. Used only with ARB_STARVE_GUARD_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DW  fetch data.
- dm_req  in  1  data request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  write data.
- dm_gnt  out  1  data granted this cycle.
- dm_rvalid  out  1  data read valid.
- dm_rdata  out  DW  data read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid RD_LAT cycles after a read strobe.
- pipe_stall  out  1  = if_req & ~if_gnt.

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0 and in the cycle after release, all outputs are 0; state=IDLE; latency counter=0; owner=none.
- Reset mid-read: the outstanding read is dropped and no rvalid is ever issued for it.
- Requester rule: req, addr, we and wdata stay stable until gnt. gnt is a one-cycle combinational pulse in the cycle the access is issued.
- mem_en, mem_we, mem_addr and mem_wdata are combinational from the winning requester in the grant cycle, else 0.
- Eligibility: a grant may issue when state=IDLE, or in the cycle the outstanding read returns (rvalid cycle). At most one grant per cycle.
- Priority: strict, dm over if.
- Write grant (dm_we=1): completes in the grant cycle. No rvalid. State stays IDLE.
- Read grant at cycle t:
  - State goes to WAIT with counter=RD_LAT and owner latched.
  - The counter decrements each cycle.
  - In cycle t+RD_LAT (counter=1 at posedge boundary), the owner's rvalid=1 and its rdata=mem_rdata. The non-owner's rdata is 0.
  - The state then returns to IDLE unless a new read is granted in the same cycle.
  - With RD_LAT=1, back-to-back reads sustain one access per cycle.
- No grants are issued during non-final WAIT cycles. Both gnt=0 and pipe_stall follows if_req.
- Simultaneous if_req and dm_req: dm_gnt=1, if_gnt=0, pipe_stall=1.
- rvalid is never asserted for writes or when there is no owner.
- Address wrap is the memory's concern; the arbiter passes AW bits unmodified.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro:
  - A counter (width $clog2(STARVE_MAX+1)) increments in each eligible cycle where if_req=1 and if_gnt=0, saturating at STARVE_MAX.
  - When the counter equals STARVE_MAX, IF wins the next eligible arbitration over dm.
  - The counter clears on if_gnt and on reset.
- Without the macro: strict dm priority, no counter logic, and STARVE_MAX is ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef arb_state_t {IDLE, WAIT}.
  - typedef owner_t {OWN_NONE, OWN_IF, OWN_DM}.
  - Constants DW_DEFAULT=32 and AW_DEFAULT=5.
- One natural sub-module, arb_lat_tracker: holds the latency counter and the owner tag, takes issue/owner inputs, and produces rvalid_if, rvalid_dm and eligible.
- The arbitration mux stays in the top module.

Test Plan:
- Reset: hold rst_n=0 with if_req=1 → all outputs 0. Release; the next eligible cycle gives if_gnt=1, mem_addr=if_addr.
- Lone fetch, RD_LAT=1, mem[3]=0x00030002, if_addr=3 → if_gnt at t, if_rvalid=1 and if_rdata=0x00030002 at t+1, pipe_stall=0.
- Conflict: if_req and dm_req (read, addr 7, mem[7]=0xFFFFFFFF) together:
  - dm_gnt at t, pipe_stall=1 at t.
  - At t+1: dm_rvalid=1 with 0xFFFFFFFF, and if_gnt=1.
  - if_rvalid at t+2.
- Write: dm_we=1, addr 2, wdata 0x5 → mem_en=1, mem_we=1 at t, no rvalid. A read of addr 2 at t+1 returns 0x5 at t+2.
- RD_LAT=3 read at t → both gnt held 0 at t+1 and t+2; rvalid at t+3 together with a new grant.
- Reset mid-read: assert rst_n=0 at t+1 of an RD_LAT=3 read → no rvalid through t+5.
- With ARB_STARVE_GUARD_EN and STARVE_MAX=4: dm_req held high continuously with if_req=1 → if_gnt in the 5th eligible cycle, then dm resumes.
